// File: rtl/alu_pkg.sv
// Shared definitions for the fetch sequencer and the downstream add/sub decoder.
package alu_pkg;

  localparam int unsigned DATA_W = 4;

  localparam logic [DATA_W-1:0] OP_ADD = 4'b1111;
  localparam logic [DATA_W-1:0] OP_SUB = 4'b0000;

  typedef enum logic [2:0] {
    StIdle,
    StRdOp,
    StRdA,
    StRdB,
    StCap,
    StPres,
    StFin
  } fetch_state_t;

  function automatic logic is_legal_op(input logic [DATA_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ROM read port plus the instruction valid/ready channel towards the decoder.
interface instr_fetch_if #(
  parameter int unsigned AddrW = 6
);
  import alu_pkg::*;

  logic              mem_en;
  logic [AddrW-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_op;
  logic [DATA_W-1:0] instr_a;
  logic [DATA_W-1:0] instr_b;
  logic [3:0]        instr_idx;

  // Fetch sequencer side.
  modport master (
    output mem_en,
    output mem_addr,
    input  mem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr_op,
    output instr_a,
    output instr_b,
    output instr_idx
  );

  // ROM / decoder side.
  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr_op,
    input  instr_a,
    input  instr_b,
    input  instr_idx
  );

endinterface

// File: rtl/instr_fetch.sv
// Walks a 1-cycle-latency program ROM, assembles (op, num_1, num_2) triples and
// hands legal ones to the decoder; illegal opcodes are skipped and flagged.
module instr_fetch
  import alu_pkg::*;
#(
  parameter int unsigned ProgDepth = 48
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [4:0]    i_prog_len,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  instr_fetch_if.master bus
);

  localparam int unsigned AddrW    = $clog2(ProgDepth);
  localparam int unsigned MaxInstr = ProgDepth / 3;
  localparam logic [4:0]  MaxLen   = 5'(MaxInstr);

  fetch_state_t      r_state;
  logic [AddrW-1:0]  r_pc;
  logic [4:0]        r_cnt;
  logic [4:0]        r_len;
  logic              r_mem_en;
  logic [AddrW-1:0]  r_mem_addr;
  logic [DATA_W-1:0] r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [3:0]        r_idx;
  logic              r_valid;
  logic              r_done;
  logic              r_err;

  logic [4:0]        w_len_clamped;
  logic [AddrW-1:0]  w_pc_next;
  logic [4:0]        w_cnt_next;
  logic              w_last;
  logic              w_op_legal;
  logic              w_advance;

  assign w_len_clamped = (i_prog_len > MaxLen) ? MaxLen : i_prog_len;
  assign w_pc_next     = r_pc + AddrW'(3);
  assign w_cnt_next    = r_cnt + 5'd1;
  assign w_last        = (w_cnt_next == r_len);
  assign w_op_legal    = is_legal_op(r_op);
  // An instruction retires either by handshake or by being skipped as illegal.
  assign w_advance     = ((r_state == StCap) && !w_op_legal) ||
                         ((r_state == StPres) && bus.instr_ready);

  // Sequencer FSM; every output is a register updated on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_pc       <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_pc  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
            r_len <= w_len_clamped;
            if (w_len_clamped == 5'd0) begin
              r_state <= StFin;
              r_done  <= 1'b1;
            end else begin
              r_state    <= StRdOp;
              r_mem_en   <= 1'b1;
              r_mem_addr <= '0;
            end
          end
        end
        StRdOp: begin
          r_state    <= StRdA;
          r_mem_addr <= r_pc + AddrW'(1);
        end
        StRdA: begin
          r_op       <= bus.mem_rdata;
          r_state    <= StRdB;
          r_mem_addr <= r_pc + AddrW'(2);
        end
        StRdB: begin
          r_a        <= bus.mem_rdata;
          r_state    <= StCap;
          r_mem_en   <= 1'b0;
          r_mem_addr <= '0;
        end
        StCap: begin
          r_b <= bus.mem_rdata;
          if (w_op_legal) begin
            r_idx   <= r_cnt[3:0];
            r_valid <= 1'b1;
            r_state <= StPres;
          end else begin
            r_err <= 1'b1;
          end
        end
        StPres: begin
          // Fields hold until the handshake; retirement handled below.
        end
        StFin: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase

      if (w_advance) begin
        r_valid <= 1'b0;
        r_cnt   <= w_cnt_next;
        r_pc    <= w_pc_next;
        if (w_last) begin
          r_state <= StFin;
          r_done  <= 1'b1;
        end else begin
          r_state    <= StRdOp;
          r_mem_en   <= 1'b1;
          r_mem_addr <= w_pc_next;
        end
      end
    end
  end

  assign bus.mem_en      = r_mem_en;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr_valid = r_valid;
  assign bus.instr_op    = r_op;
  assign bus.instr_a     = r_a;
  assign bus.instr_b     = r_b;
  assign bus.instr_idx   = r_idx;
  assign o_busy          = (r_state != StIdle);
  assign o_done          = r_done;
  assign o_err           = r_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch against a list-level model of the program.
module tb_instr_fetch;

  localparam int unsigned ProgDepth = 48;
  localparam int unsigned MaxInstr  = 16;
  localparam int unsigned AddrW     = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] prog_len = '0;
  logic       busy;
  logic       done;
  logic       err;

  instr_fetch_if #(.AddrW(AddrW)) bus ();

  instr_fetch #(.ProgDepth(ProgDepth)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (start),
    .i_prog_len(prog_len),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // prog_rom: synchronous, one cycle of read latency.
  logic [3:0] rom [ProgDepth];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= (int'(bus.mem_addr) < ProgDepth) ? rom[bus.mem_addr] : 4'h0;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] idx;
    int         cyc;
  } hs_t;

  function automatic bit legal(input logic [3:0] op);
    return (op == 4'hF) || (op == 4'h0);
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({bus.mem_en, bus.mem_addr, bus.instr_valid, bus.instr_op, bus.instr_a,
                bus.instr_b, bus.instr_idx, busy, done, err});
  endfunction

  task automatic fill_random_rom();
    for (int i = 0; i < ProgDepth; i++) begin
      if (i % 3 == 0) begin
        case ($urandom_range(0, 3))
          0:       rom[i] = 4'hF;
          1:       rom[i] = 4'h0;
          default: rom[i] = 4'($urandom_range(0, 15));
        endcase
      end else begin
        rom[i] = 4'($urandom_range(0, 15));
      end
    end
  endtask

  // mode 0: ready always high, exact timing checked; 1: random ready;
  // 2: ready withheld for the first 7 cycles of presentation.
  // poke: pulse start mid-run and during FIN, both of which must be ignored.
  task automatic run_prog(input int len, input int mode, input bit poke);
    hs_t        exp_q[$];
    hs_t        got_q[$];
    hs_t        h;
    int         lc;
    int         s;
    int         exp_done;
    bit         exp_err;
    bit         last_legal;
    int         cyc;
    bit         done_seen;
    int         done_cyc;
    int         max_addr;
    int         n_reads;
    int         n_stall_rd;
    int         n_unstable;
    int         n_addr_idle;
    int         stall_left;
    bit         prev_hold;
    logic [15:0] prev_fields;
    logic [15:0] cur_fields;
    logic       rdy;
    logic [6:0] e_rd;

    // Model: the run is a list of triples; legal ones take 5 cycles, skips take 4.
    lc = (len > MaxInstr) ? MaxInstr : len;
    s = 0;
    exp_err = 1'b0;
    last_legal = 1'b0;
    for (int i = 0; i < lc; i++) begin
      if (legal(rom[3*i])) begin
        h.op  = rom[3*i];
        h.a   = rom[3*i+1];
        h.b   = rom[3*i+2];
        h.idx = 4'(i);
        h.cyc = s + 4;
        exp_q.push_back(h);
        s += 5;
        last_legal = 1'b1;
      end else begin
        exp_err = 1'b1;
        s += 4;
        last_legal = 1'b0;
      end
    end
    exp_done = s;

    start    = 1'b1;
    prog_len = 5'(len);
    @(negedge clk);
    start = 1'b0;

    cyc = 0;
    done_seen = 1'b0;
    done_cyc = -1;
    max_addr = 0;
    n_reads = 0;
    n_stall_rd = 0;
    n_unstable = 0;
    n_addr_idle = 0;
    stall_left = 7;
    prev_hold = 1'b0;
    prev_fields = '0;
    while (!done_seen && cyc < 3000) begin
      cur_fields = {bus.instr_op, bus.instr_a, bus.instr_b, bus.instr_idx};
      if (cyc == 0) begin
        check("busy_on_start", busy, 1);
        check("err_cleared", err, 0);
        e_rd = {(lc > 0), 6'd0};
        check("first_rd", {bus.mem_en, bus.mem_addr}, e_rd);
      end
      if (bus.mem_en) begin
        n_reads++;
        if (int'(bus.mem_addr) > max_addr) max_addr = int'(bus.mem_addr);
        if (bus.instr_valid) n_stall_rd++;
      end else if (bus.mem_addr != '0) begin
        n_addr_idle++;
      end
      if (prev_hold && (!bus.instr_valid || cur_fields != prev_fields)) n_unstable++;
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end

      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = !(bus.instr_valid && stall_left > 0);
          if (bus.instr_valid && stall_left > 0) stall_left--;
        end
      endcase
      bus.instr_ready = rdy;
      if (bus.instr_valid && rdy) begin
        h.op  = bus.instr_op;
        h.a   = bus.instr_a;
        h.b   = bus.instr_b;
        h.idx = bus.instr_idx;
        h.cyc = cyc;
        got_q.push_back(h);
      end
      prev_hold   = bus.instr_valid && !rdy;
      prev_fields = cur_fields;

      start = 1'b0;
      if (poke && cyc == 2) begin
        start    = 1'b1;
        prog_len = 5'd0;
      end
      if (!done_seen) begin
        @(negedge clk);
        cyc++;
      end
    end

    check("done_seen", done_seen, 1);
    if (mode == 0) begin
      check("done_cyc", done_cyc, exp_done);
    end else if (last_legal && got_q.size() > 0) begin
      check("done_after_hs", done_cyc, got_q[got_q.size()-1].cyc + 1);
    end
    check("err", err, exp_err);
    check("n_instr", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("instr", {got_q[i].op, got_q[i].a, got_q[i].b, got_q[i].idx},
            {exp_q[i].op, exp_q[i].a, exp_q[i].b, exp_q[i].idx});
      if (mode == 0) check("hs_cyc", got_q[i].cyc, exp_q[i].cyc);
    end
    check("n_reads", n_reads, 3 * lc);
    check("max_addr", max_addr, (lc > 0) ? 3 * lc - 1 : 0);
    check("no_rd_in_stall", n_stall_rd, 0);
    check("stable_hold", n_unstable, 0);
    check("addr_idle_zero", n_addr_idle, 0);

    // A start while in FIN must be dropped.
    start = poke;
    @(negedge clk);
    start = 1'b0;
    check("idle_after_fin", {busy, done}, 0);
    check("err_sticky", err, exp_err);
    bus.instr_ready = 1'b1;
  endtask

  initial begin
    bus.instr_ready = 1'b1;
    for (int i = 0; i < ProgDepth; i++) rom[i] = 4'h0;

    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two legal instructions.
    rom[0] = 4'hF; rom[1] = 4'h3; rom[2] = 4'h4;
    rom[3] = 4'h0; rom[4] = 4'h9; rom[5] = 4'h2;
    run_prog(2, 0, 1'b0);

    // Backpressure on the first presentation.
    run_prog(2, 2, 1'b0);

    // Illegal opcode first, with ignored start pulses mid-run and in FIN.
    rom[0] = 4'h5; rom[1] = 4'h1; rom[2] = 4'h1;
    rom[3] = 4'hF; rom[4] = 4'h2; rom[5] = 4'h3;
    run_prog(2, 0, 1'b1);

    // Zero-length run, then an over-long one that must clamp to 16.
    run_prog(0, 0, 1'b0);
    fill_random_rom();
    run_prog(20, 0, 1'b0);

    // Asynchronous reset during RD_B.
    rom[0] = 4'hF; rom[1] = 4'h3; rom[2] = 4'h4;
    rom[3] = 4'h0; rom[4] = 4'h9; rom[5] = 4'h2;
    start    = 1'b1;
    prog_len = 5'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rdb_addr", bus.mem_addr, 2);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_prog(2, 0, 1'b0);

    // Random programs, lengths, ready patterns and ignored starts.
    repeat (30) begin
      fill_random_rom();
      run_prog(int'($urandom_range(0, 20)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
